// File: rtl/me_coord_nlane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | me_coord_nlane: N-lane ME coordinator - age sort, stall, redirect    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module me_coord_nlane #(
  parameter int LANES     = 2,
  parameter int XLEN      = 32,
  parameter int ORD_W     = 3,
  parameter int FLUSH_CYC = 1
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic [LANES-1:0]       ex_valid,
  input  logic [LANES*ORD_W-1:0] ex_order,
  input  logic [LANES*5-1:0]     ex_rd,
  input  logic [LANES-1:0]       ex_regwrite,
  input  logic [LANES*XLEN-1:0]  ex_alu,
  input  logic [LANES-1:0]       ex_pcsrc,
  input  logic [LANES*XLEN-1:0]  ex_bradd,
  input  logic [LANES-1:0]       memhaz,
  input  logic [LANES-1:0]       wb_stall,
  output logic [LANES-1:0]       me_stall,
  output logic [LANES*XLEN-1:0]  fwd_data,
  output logic [LANES*5-1:0]     fwd_rd,
  output logic [LANES-1:0]       fwd_wten,
  output logic [LANES-1:0]       wb_valid,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [ORD_W-1:0]       head_order
);

  localparam int         CW         = 3;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC);

  logic [LANES-1:0] valid_q, valid_d;
  logic [LANES-1:0] regwrite_q, regwrite_d;
  logic [LANES-1:0] pcsrc_q, pcsrc_d;
  logic [ORD_W-1:0] order_q [LANES];
  logic [ORD_W-1:0] order_d [LANES];
  logic [4:0]       rd_q    [LANES];
  logic [4:0]       rd_d    [LANES];
  logic [XLEN-1:0]  alu_q   [LANES];
  logic [XLEN-1:0]  alu_d   [LANES];
  logic [XLEN-1:0]  bradd_q [LANES];
  logic [XLEN-1:0]  bradd_d [LANES];
  logic [ORD_W-1:0] head_q, head_d;
  logic [2:0]       flush_q, flush_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;

  logic [ORD_W-1:0] age   [LANES];
  logic [LANES-1:0] older [LANES];
  logic [CW-1:0]    rank  [LANES];
  logic [LANES-1:0] lane_wbs, own_stall, stall, br, cand, squash, retire;
  logic             redirect, flushing;
  logic [ORD_W-1:0] redir_order;
  logic [XLEN-1:0]  redir_pc;
  logic [CW-1:0]    nret;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      valid_q          <= '0;
      regwrite_q       <= '0;
      pcsrc_q          <= '0;
      head_q           <= '0;
      flush_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        order_q[i] <= '0;
        rd_q[i]    <= '0;
        alu_q[i]   <= '0;
        bradd_q[i] <= '0;
      end
    end else begin
      valid_q          <= valid_d;
      regwrite_q       <= regwrite_d;
      pcsrc_q          <= pcsrc_d;
      head_q           <= head_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      order_q          <= order_d;
      rd_q             <= rd_d;
      alu_q            <= alu_d;
      bradd_q          <= bradd_d;
    end
  end

  always_comb begin
    // older[i][j]: lane j is a valid lane ahead of lane i; invalid lanes sit behind every valid one
    for (int i = 0; i < LANES; i++) begin
      age[i] = order_q[i] - head_q;
    end
    for (int i = 0; i < LANES; i++) begin
      older[i] = '0;
      for (int j = 0; j < LANES; j++) begin
        if (j != i && valid_q[j]) begin
          if (!valid_q[i] || (age[j] < age[i]) || (age[j] == age[i] && j < i)) begin
            older[i][j] = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < LANES; i++) begin
      rank[i] = '0;
      for (int j = 0; j < LANES; j++) begin
        rank[i] = rank[i] + CW'(older[i][j]);
        if (!valid_q[i] && !valid_q[j] && j < i) begin
          rank[i] = rank[i] + 3'd1;
        end
      end
    end

    for (int i = 0; i < LANES; i++) begin
      lane_wbs[i] = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        if (rank[i] == CW'(k)) begin
          lane_wbs[i] = lane_wbs[i] | wb_stall[k];
        end
      end
    end
    own_stall = valid_q & (memhaz | lane_wbs);

    br = valid_q & pcsrc_q;
    for (int i = 0; i < LANES; i++) begin
      stall[i] = own_stall[i] | (|(older[i] & own_stall));
    end
    // Only the oldest branch may redirect; a stalled one blocks younger branches by propagation
    for (int i = 0; i < LANES; i++) begin
      cand[i] = br[i] & ~stall[i] & ~(|(older[i] & br));
    end
    redirect    = |cand;
    redir_order = '0;
    redir_pc    = '0;
    for (int i = 0; i < LANES; i++) begin
      redir_order = redir_order | (order_q[i] & {ORD_W{cand[i]}});
      redir_pc    = redir_pc | (bradd_q[i] & {XLEN{cand[i]}});
      squash[i]   = valid_q[i] & (|(older[i] & cand));
    end
    retire = valid_q & ~stall & ~squash;
    nret   = '0;
    for (int i = 0; i < LANES; i++) begin
      nret = nret + CW'(retire[i]);
    end

    fwd_data = '0;
    fwd_rd   = '0;
    fwd_wten = '0;
    wb_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < LANES; i++) begin
        if (valid_q[i] && rank[i] == CW'(k)) begin
          fwd_data[k*XLEN +: XLEN] = alu_q[i];
          fwd_rd[k*5 +: 5]         = rd_q[i];
          fwd_wten[k]              = regwrite_q[i] & (rd_q[i] != 5'd0) & ~squash[i];
          wb_valid[k]              = retire[i];
        end
      end
    end
    me_stall = stall;

    flushing         = redirect | (flush_q != 3'd0);
    flush_d          = redirect ? FLUSH_INIT : ((flush_q != 3'd0) ? flush_q - 3'd1 : 3'd0);
    head_d           = redirect ? redir_order + ORD_W'(1) : head_q + ORD_W'(nret);
    redirect_valid_d = redirect;
    redirect_pc_d    = redirect ? redir_pc : '0;

    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    pcsrc_d    = pcsrc_q;
    order_d    = order_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    bradd_d    = bradd_q;
    for (int i = 0; i < LANES; i++) begin
      if (!stall[i]) begin
        valid_d[i]    = ex_valid[i] & ~flushing;
        regwrite_d[i] = ex_regwrite[i];
        pcsrc_d[i]    = ex_pcsrc[i];
        order_d[i]    = ex_order[i*ORD_W +: ORD_W];
        rd_d[i]       = ex_rd[i*5 +: 5];
        alu_d[i]      = ex_alu[i*XLEN +: XLEN];
        bradd_d[i]    = ex_bradd[i*XLEN +: XLEN];
      end else if (squash[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign head_order     = head_q;

endmodule
`default_nettype wire

// File: doc/me_coord_nlane.md
Name: me_coord_nlane

Overview:
Parametrised N-lane memory-stage coordinator for the superscalar core. It is the successor to the fixed dual-lane ME coordination logic.
It latches per-lane ME entries from EX and tracks program age with a wrap-around order-tag head pointer. It enforces in-order stall propagation, selects the oldest taken branch/redirect, squashes younger wrong-path lanes, and presents retiring results to WB in age-sorted slots.
It also drives registered redirect and forwarding outputs to fetch and EX.

Parameters:
LANES, 2, number of issue lanes (1..4)
XLEN, 32, data/address width
ORD_W, 3, order-tag width; in-flight tag spread must stay < 2^(ORD_W-1)
FLUSH_CYC, 1, cycles of incoming-entry drop after a redirect (1..7)

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  asynchronous active-low reset
ex_valid  in  LANES  per-lane entry valid from EX
ex_order  in  LANES*ORD_W  per-lane order tag
ex_rd  in  LANES*5  destination register
ex_regwrite  in  LANES  register write request
ex_alu  in  LANES*XLEN  ALU result
ex_pcsrc  in  LANES  taken branch/jump
ex_bradd  in  LANES*XLEN  branch target
memhaz  in  LANES  per-lane memory hazard, already aligned to ME registers
wb_stall  in  LANES  per-slot backpressure from WB
me_stall  out  LANES  per-lane hold to EX (combinational)
fwd_data  out  LANES*XLEN  age-sorted forwarding data, slot 0 oldest
fwd_rd  out  LANES*5  age-sorted rd
fwd_wten  out  LANES  age-sorted write enable
wb_valid  out  LANES  age-sorted retire strobe
redirect_valid  out  1  registered redirect pulse
redirect_pc  out  XLEN  registered redirect target
head_order  out  ORD_W  current oldest expected order tag

Behaviour:
- Reset (RST_n=0, async): clear all lane registers (valid=0), head_order=0, flush counter=0, redirect_valid=0, redirect_pc=0.
- Outputs during reset: me_stall=0, wb_valid=0, fwd_*=0.
- Age: age_i = (r_order_i - head_order) mod 2^ORD_W. Smaller age is older. On equal age, the lower lane index is older.
- Slot k holds the k-th oldest valid lane. Invalid lanes sort after all valid lanes and drive zero in their slot.
- Own hazard: own_stall_i = r_valid_i & (memhaz_i | wb_stall[slot of i]).
- In-order stall propagation: me_stall_i = own_stall_i OR own_stall of any older valid lane. Older lanes are never held by younger lanes.
- Wten: fwd_wten = regwrite & (rd != 0) & valid & ~squash.
- Redirect candidate: the oldest valid, non-stalled lane with r_pcsrc=1. If any older lane is stalled, no redirect fires that cycle.
- Squash: all valid lanes younger than the redirect candidate. Squashed lanes have wb_valid=0 and fwd_wten=0, and are cleared at the next edge regardless of stall.
- Retire: wb_valid[slot] = valid & ~me_stall & ~squash.
- head_order update, normal cycle: advances by the count of retired lanes (mod 2^ORD_W).
- head_order update, redirect cycle: set to candidate order + 1. The front end restarts tag numbering from that value.
- Redirect output: redirect_valid and redirect_pc are registered; they assert exactly one cycle after the decision, for one cycle.
- Flush: on a redirect decision, load flush counter with FLUSH_CYC. While counter != 0, ex_valid is ignored (lanes load valid=0) and the counter decrements. This includes the decision cycle's load.
- Lane register load: when me_stall_i=0, lane i loads the EX inputs. When stalled and not squashed, it holds.
- Simultaneous retire + redirect: the redirecting lane itself retires in the same cycle.
- LANES=1: no sorting, no squash. Stall = own_stall only.
- Async reset mid-flush or mid-stall: all state is cleared immediately and no redirect pulse follows.

Test Plan:
- Reset: hold RST_n=0 with ex_valid=2'b11 -> all outputs 0, head_order=0. Release -> first load appears next cycle.
- Ordering (LANES=2): lane0 order=1, lane1 order=0, head=0 -> slot0 = lane1 data, slot1 = lane0 data. After both retire, head_order=2.
- Wrap-around: head=7, lane0 order=0, lane1 order=7 -> lane1 oldest. After both retire, head_order=1.
- Stall propagation: older lane memhaz=1 -> me_stall=2'b11 and wb_valid=0. Younger lane memhaz=1 only -> only the younger lane is stalled, and the older lane retires.
- Redirect: older lane pcsrc=1, bradd=0x80000100, younger lane regwrite=1 rd=5 -> younger fwd_wten=0 and wb_valid=0. Next cycle redirect_valid=1 and redirect_pc=0x80000100. Next-cycle ex_valid=2'b11 is dropped (FLUSH_CYC=1). head_order = older order + 1.
- Both lanes pcsrc=1 -> only the older lane's target appears on redirect_pc. Repeat with the older lane stalled -> no redirect until the stall clears.
